// File: rtl/booth_mul_seq.sv
// Purpose : sequential signed radix-2 Booth multiplier; drives an external (WIDTH+1)-bit adder once per iteration.
// Latency : done/product in cycle 2*WIDTH+1 after start is sampled high in IDLE (17 cycles for WIDTH=8).
// Backpr. : no queueing; start is only sampled in IDLE, so requests made while busy (including the DONE cycle) are dropped.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start             multiply request, sampled only in IDLE
//   mcand, mplier     signed operands, captured when start is accepted
//   add_x/add_y/add_cin  operands to the external adder; add_z is its combinational sum
//   busy              high from the cycle after start is accepted through the DONE cycle
//   done              one-cycle pulse; product valid from that cycle and held until the next completion
//   product           signed 2*WIDTH-bit result
module booth_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     mplier,
    output logic [WIDTH:0]       add_x,
    output logic [WIDTH:0]       add_y,
    output logic                 add_cin,
    input  logic [WIDTH:0]       add_z,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADD   = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [WIDTH:0]     acc;        // one guard bit so -2^(W-1) * -2^(W-1) cannot overflow
    logic [WIDTH-1:0]   q;
    logic               q_1;
    logic [WIDTH:0]     m;          // sign-extended multiplicand
    logic [CNT_W-1:0]   cnt;

    logic               last_iter;
    logic [WIDTH:0]     acc_sh;
    logic [WIDTH-1:0]   q_sh;

    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    // Arithmetic right shift of {acc, q, q_1}; acc[WIDTH] is replicated.
    assign acc_sh = {acc[WIDTH], acc[WIDTH:1]};
    assign q_sh   = {acc[0], q[WIDTH-1:1]};

    assign add_x = acc;

    // Next state and adder operand mux. Subtraction is ~M with carry-in 1.
    always_comb begin
        state_nxt = state;
        add_y     = '0;
        add_cin   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_ADD;
                end
            end
            S_ADD: begin
                case ({q[0], q_1})
                    2'b01: begin
                        add_y = m;
                    end
                    2'b10: begin
                        add_y   = ~m;
                        add_cin = 1'b1;
                    end
                    default: begin
                        add_y   = '0;
                        add_cin = 1'b0;
                    end
                endcase
                state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                state_nxt = last_iter ? S_DONE : S_ADD;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            acc     <= '0;
            q       <= '0;
            q_1     <= 1'b0;
            m       <= '0;
            cnt     <= '0;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc  <= '0;
                        q    <= mplier;
                        q_1  <= 1'b0;
                        m    <= {mcand[WIDTH-1], mcand};
                        cnt  <= '0;
                        busy <= 1'b1;
                    end
                end
                S_ADD: begin
                    acc <= add_z;
                end
                S_SHIFT: begin
                    acc <= acc_sh;
                    q   <= q_sh;
                    q_1 <= q[0];
                    if (last_iter) begin
                        // Load the result on entry to DONE so it is valid while done is high.
                        product <= {acc_sh[WIDTH-1:0], q_sh};
                        done    <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                end
                default: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mul_seq.sv
module tb_booth_mul_seq;

    localparam int W   = 8;
    localparam int LAT = 2 * W + 1;

    logic             clk;
    logic             rst;
    logic             start;
    logic [W-1:0]     mcand;
    logic [W-1:0]     mplier;
    logic [W:0]       add_x;
    logic [W:0]       add_y;
    logic             add_cin;
    logic [W:0]       add_z;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   product;

    int errors = 0;
    int checks = 0;

    booth_mul_seq #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .mcand   (mcand),
        .mplier  (mplier),
        .add_x   (add_x),
        .add_y   (add_y),
        .add_cin (add_cin),
        .add_z   (add_z),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    // External ripple-carry adder stand-in.
    assign add_z = add_x + add_y + (W+1)'(add_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain signed integer multiply truncated to 2*W bits.
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        int sa;
        int sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        return (2*W)'(sa * sb);
    endfunction

    // One complete operation from IDLE; operands are scrambled while busy.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        int n;
        bit seen;
        bit mux_bad;
        bit busy_bad;
        logic [2*W-1:0] exp;
        exp = ref_mul(a, b);
        @(negedge clk);
        start  = 1'b1;
        mcand  = a;
        mplier = b;
        @(negedge clk);
        start  = 1'b0;
        mcand  = W'($urandom);
        mplier = W'($urandom);
        n = 1; seen = 0; mux_bad = 0; busy_bad = 0;
        while (n <= 40 && !seen) begin
            if (done) seen = 1;
            if (!busy) busy_bad = 1;
            // Even cycles are SHIFT and the done cycle is DONE: adder operand must be idle.
            if (((n % 2) == 0 || done) && (add_y != '0 || add_cin != 1'b0)) mux_bad = 1;
            if (!seen) begin
                @(negedge clk);
                n++;
                mcand  = W'($urandom);
                mplier = W'($urandom);
            end
        end
        check({tag, "_latency"}, n, LAT);
        check({tag, "_product"}, product, exp);
        check({tag, "_mux_idle"}, mux_bad, 0);
        check({tag, "_busy"}, busy_bad, 0);
        @(negedge clk);
        check({tag, "_idle"}, {add_cin, add_y, busy, done}, 0);
    endtask

    initial begin
        int ndone;
        logic [W-1:0] qa[$];
        logic [W-1:0] qb[$];
        logic [W-1:0] na;
        logic [W-1:0] nb;

        rst = 1'b1; start = 1'b0; mcand = '0; mplier = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_product", product, 0);
        check("reset_adder", {add_cin, add_y, add_x}, 0);
        rst = 1'b0;

        // Directed cases, including the most-negative boundary.
        run_op(8'd3,    8'd5,    "d_3x5");
        check("d_3x5_value", product, 16'h000F);
        run_op(8'h80,   8'h80,   "d_min_min");
        check("d_min_min_value", product, 16'h4000);
        run_op(8'h80,   8'h7F,   "d_min_max");
        check("d_min_max_value", product, 16'hC080);
        run_op(8'hFF,   8'hFF,   "d_m1_m1");
        check("d_m1_m1_value", product, 16'h0001);
        run_op(8'h00,   8'h5A,   "d_zero");
        check("d_zero_value", product, 16'h0000);
        run_op(8'h7F,   8'h7F,   "d_max_max");
        check("d_max_max_value", product, 16'h3F01);

        // Abort with reset in cycle 7 of an operation.
        @(negedge clk);
        start = 1'b1; mcand = 8'd9; mplier = 8'hF9;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_product", product, 0);
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 0);
        check("abort_product_held", product, 0);
        run_op(8'd2, 8'd3, "abort_fresh");
        check("abort_fresh_value", product, 16'h0006);

        // start held high: one result every 2*W+2 cycles, operands sampled at acceptance only.
        ndone = 0;
        @(negedge clk);
        na = W'($urandom); nb = W'($urandom);
        qa.push_back(na); qb.push_back(nb);
        start = 1'b1; mcand = na; mplier = nb;
        for (int c = 1; c <= 3 * (LAT + 1); c++) begin
            @(negedge clk);
            if (done) begin
                check("b2b_cycle", c, LAT + (LAT + 1) * ndone);
                if (ndone < qa.size()) check("b2b_product", product, ref_mul(qa[ndone], qb[ndone]));
                ndone++;
            end
            if ((c % (LAT + 1)) == 0 && c < 3 * (LAT + 1)) begin
                na = W'($urandom); nb = W'($urandom);
                qa.push_back(na); qb.push_back(nb);
                mcand = na; mplier = nb;
            end else begin
                mcand  = W'($urandom);
                mplier = W'($urandom);
            end
            if (c == 3 * (LAT + 1)) start = 1'b0;
        end
        @(negedge clk);
        check("b2b_count", ndone, 3);
        check("b2b_idle", {busy, done}, 0);

        // Randomised operand pairs.
        for (int i = 0; i < 512; i++) begin
            run_op(W'($urandom), W'($urandom), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
